// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter that owns the select lines of a shared 4:1 mux path.
// Each requester holds its req bit high while it needs the path. Once a
// requester is granted, it keeps the grant until it drops its request or
// until it has held the path for MAX_HOLD cycles. The grant then rotates to
// the next requester after the owner.
//
// Parameters:
//   MAX_HOLD  maximum consecutive cycles one grant is held (1..255)
// Ports:
//   clk   in   single clock, rising edge
//   rst   in   synchronous active-high reset
//   req   in   [3:0] level-sensitive request per requester
//   gnt   out  [3:0] registered one-hot grant, zero when there is no owner
//   s0    out  registered mux select bit 0 (owner index bit 0)
//   s1    out  registered mux select bit 1 (owner index bit 1)
//   busy  out  registered, high exactly while gnt is non-zero
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state;
    logic [1:0] own;
    logic [1:0] ptr;
    logic [7:0] cnt;

    logic [1:0] base;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    logic       grant_end;

    // Priority search. In IDLE the search starts at the rotating pointer.
    // In GRANT it starts just after the owner, which equals the pointer value
    // the grant will leave behind when it ends. The owner is therefore always
    // checked last. On a release the owner's request is already low, so this
    // single search also covers the "other three only" case.
    // The loop runs from the farthest offset down, so the nearest set request
    // is the final write and wins.
    always_comb begin
        base  = (state == GRANT) ? own + 2'd1 : ptr;
        idx   = base;
        win   = base;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // The current grant ends on a release or on expiry of the hold window.
    // A release takes precedence, but both cases resolve through the same
    // search, so a single flag is enough.
    always_comb begin
        grant_end = (state == GRANT) && (!req[own] || (cnt == CNT_LAST));
    end

    // State, owner, pointer, hold counter and all registered outputs.
    // The outputs are loaded together with the owner, so they show the new
    // owner one cycle after the deciding edge. While idle, the selects keep
    // their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            own   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= 8'd0;
            gnt   <= 4'b0000;
            s0    <= 1'b0;
            s1    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        own   <= win;
                        cnt   <= 8'd0;
                        gnt   <= 4'b0001 << win;
                        s0    <= win[0];
                        s1    <= win[1];
                        busy  <= 1'b1;
                    end else begin
                        gnt  <= 4'b0000;
                        busy <= 1'b0;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        ptr <= own + 2'd1;
                        if (found) begin
                            own  <= win;
                            cnt  <= 8'd0;
                            gnt  <= 4'b0001 << win;
                            s0   <= win[0];
                            s1   <= win[1];
                            busy <= 1'b1;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
// Self-checking bench for mux4_rr_arbiter. It runs four instances side by
// side with MAX_HOLD = 1, 2, 4 and 8. All four share clk, rst and req.
// A behavioural model tracks the owner, the pointer and the held-cycle count
// for each instance, and the outputs of every instance are compared after
// every clock edge.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] gntA  [4];
    logic       s0A   [4];
    logic       s1A   [4];
    logic       busyA [4];

    int total = 0;
    int bad   = 0;

    int maxh  [4] = '{1, 2, 4, 8};
    int owner [4];
    int ptr   [4];
    int held  [4];
    int sel   [4];

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mux4_rr_arbiter #(
            .MAX_HOLD((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8)
        ) dut (
            .clk (clk),
            .rst (rst),
            .req (req),
            .gnt (gntA[g]),
            .s0  (s0A[g]),
            .s1  (s1A[g]),
            .busy(busyA[g])
        );
    end

    // One comparison: counts it, and reports it when it fails.
    task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference behaviour. The model applies the arbitration rules directly
    // to the inputs sampled at the current edge.
    task automatic modelStep(input logic [3:0] r, input logic rs);
        for (int k = 0; k < 4; k++) begin
            int nw;
            nw = -1;
            if (rs) begin
                owner[k] = -1;
                ptr[k]   = 0;
                held[k]  = 0;
                sel[k]   = 0;
            end else if (owner[k] < 0) begin
                for (int j = 0; j < 4; j++)
                    if (nw < 0 && r[(ptr[k] + j) % 4]) nw = (ptr[k] + j) % 4;
                if (nw >= 0) begin
                    owner[k] = nw;
                    held[k]  = 0;
                    sel[k]   = nw;
                end
            end else if (!r[owner[k]]) begin
                ptr[k] = (owner[k] + 1) % 4;
                for (int j = 0; j < 3; j++)
                    if (nw < 0 && r[(ptr[k] + j) % 4]) nw = (ptr[k] + j) % 4;
                owner[k] = nw;
                held[k]  = 0;
                if (nw >= 0) sel[k] = nw;
            end else if (held[k] == maxh[k] - 1) begin
                ptr[k] = (owner[k] + 1) % 4;
                for (int j = 0; j < 4; j++)
                    if (nw < 0 && r[(ptr[k] + j) % 4]) nw = (ptr[k] + j) % 4;
                owner[k] = nw;
                held[k]  = 0;
                sel[k]   = nw;
            end else begin
                held[k]++;
            end
        end
    endtask

    // Compare every instance against the model.
    task automatic checkOutput();
        for (int k = 0; k < 4; k++) begin
            logic [3:0] eg;
            eg = (owner[k] < 0) ? 4'b0000 : (4'b0001 << owner[k]);
            checkOne($sformatf("gnt[h%0d]", maxh[k]), gntA[k], eg);
            checkOne($sformatf("sel[h%0d]", maxh[k]), {2'b00, s1A[k], s0A[k]}, 4'(sel[k]));
            checkOne($sformatf("busy[h%0d]", maxh[k]), {3'b000, busyA[k]}, {3'b000, owner[k] >= 0});
            checkOne($sformatf("onehot[h%0d]", maxh[k]), {3'b000, $countones(gntA[k]) > 1}, 4'b0000);
        end
    endtask

    // Drive one cycle of inputs at the falling edge. After the next rising
    // edge, update the model and check the outputs.
    task automatic applyStimulus(input logic [3:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        @(posedge clk);
        modelStep(r, rs);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [3:0] seq26 [9];
        logic [3:0] rr;
        seq26 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                  4'b0100, 4'b1000, 4'b1000, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            owner[k] = -1;
            ptr[k]   = 0;
            held[k]  = 0;
            sel[k]   = 0;
        end

        // Reset held for two cycles while all requests are active.
        applyStimulus(4'b1111, 1'b1);
        applyStimulus(4'b1111, 1'b1);

        // Reset released with all requests active. With MAX_HOLD=2 the grant
        // rotates in pairs of cycles, with no gap cycles.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'b1111, 1'b0);
            checkOne($sformatf("seq26[%0d]", i), gntA[1], seq26[i]);
        end

        // Single request from IDLE, then drop it.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0100, 1'b0);
        checkOne("req0100_gnt", gntA[3], 4'b0100);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOne("drop_gnt", gntA[3], 4'b0000);
        applyStimulus(4'b0000, 1'b0);

        // Owner 1 releases while req=1001, so requester 3 is granted next.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b1011, 1'b0);
        applyStimulus(4'b1001, 1'b0);
        checkOne("release_gnt", gntA[3], 4'b1000);
        checkOne("release_sel", {2'b00, s1A[3], s0A[3]}, 4'b0011);

        // Only requester 0 for ten cycles. It is re-granted on expiry with no gap.
        applyStimulus(4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0001, 1'b0);
            checkOne($sformatf("solo0[%0d]", i), gntA[2], 4'b0001);
        end

        // Reset pulsed mid-grant. The first grant after reset uses ptr=0.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b1111, 1'b1);
        checkOne("rst_mid_gnt", gntA[3], 4'b0000);
        applyStimulus(4'b1111, 1'b0);
        checkOne("post_rst_gnt", gntA[3], 4'b0001);

        // Random traffic. Requests mostly persist, with occasional resets.
        rr = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
            applyStimulus(rr, $urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
